// File: rtl/adler32_frame_checker.sv
// Adler-32 frame checker: captures the 4-byte trailer after each payload and compares it
// with the generator checksum. Define ADLER32_FAIL_COUNT_EN to add a saturating fail_count output.
module adler32_frame_checker #(
  parameter int SIZE_W  = 32,
  parameter int TIMEOUT = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE_W-1:0] size,
  input  logic              size_valid,
  input  logic              data_start,
  input  logic [7:0]        data,
  input  logic [31:0]       checksum,
  input  logic              checksum_valid,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [31:0]       rx_checksum
`ifdef ADLER32_FAIL_COUNT_EN
  ,
  output logic [15:0]       fail_count
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, PAYLOAD, TRAILER, WAIT, REPORT} state_t;

  state_t            state, state_nx;
  logic [SIZE_W-1:0] size_reg, remaining;
  logic [1:0]        tcnt;
  logic [31:0]       gen_sum;
  logic              got_gen, to_flag;
  logic [TW-1:0]     to_cnt;
  logic              to_hit, gen_take, shift_en, start_cnt, set_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    start_cnt = 1'b0;
    set_to    = 1'b0;
    pass      = 1'b0;
    fail      = 1'b0;
    timeout   = 1'b0;
    // a checksum arriving in the same cycle as the deadline still counts as an answer
    to_hit    = !got_gen && !checksum_valid && (to_cnt == TO_MAX);
    gen_take  = checksum_valid && (state inside {PAYLOAD, TRAILER, WAIT});
    case (state)
      IDLE: if (data_start) begin
        if (size_reg == '0) begin
          state_nx  = TRAILER;
          shift_en  = 1'b1;
          start_cnt = 1'b1;
        end else if (size_reg == SIZE_W'(1)) begin
          state_nx  = TRAILER;
          start_cnt = 1'b1;
        end else begin
          state_nx  = PAYLOAD;
        end
      end
      PAYLOAD: if (remaining <= SIZE_W'(1)) begin
        state_nx  = TRAILER;
        start_cnt = 1'b1;
      end
      TRAILER: if (to_hit) begin
        state_nx = REPORT;
        set_to   = 1'b1;
      end else begin
        shift_en = 1'b1;
        if (tcnt == 2'd3) state_nx = (got_gen || checksum_valid) ? REPORT : WAIT;
      end
      WAIT: if (checksum_valid || to_hit) begin
        state_nx = REPORT;
        set_to   = to_hit;
      end
      REPORT: begin
        state_nx = IDLE;
        pass     = got_gen && !to_flag && (gen_sum == rx_checksum);
        fail     = !pass;
        timeout  = to_flag;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_reg    <= '0;
      remaining   <= '0;
      tcnt        <= '0;
      rx_checksum <= '0;
      gen_sum     <= '0;
      got_gen     <= 1'b0;
      to_flag     <= 1'b0;
      to_cnt      <= '0;
    end else begin
      if (state == IDLE && size_valid) size_reg <= size;

      if (state == IDLE && data_start)
        remaining <= (size_reg != '0) ? size_reg - SIZE_W'(1) : '0;
      else if (state == PAYLOAD && remaining != '0)
        remaining <= remaining - SIZE_W'(1);

      if (shift_en) rx_checksum <= {rx_checksum[23:0], data};

      // size-0 frames take their first trailer byte together with data_start
      if (state == IDLE)  tcnt <= {1'b0, shift_en};
      else if (shift_en)  tcnt <= tcnt + 2'd1;

      if (start_cnt)
        to_cnt <= '0;
      else if ((state inside {TRAILER, WAIT}) && !got_gen && to_cnt != TO_MAX)
        to_cnt <= to_cnt + TW'(1);

      if (gen_take) begin
        gen_sum <= checksum;
        got_gen <= 1'b1;
      end else if (state == REPORT) begin
        got_gen <= 1'b0;
      end

      if (set_to)               to_flag <= 1'b1;
      else if (state == REPORT) to_flag <= 1'b0;
    end
  end

`ifdef ADLER32_FAIL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       fail_count <= '0;
    else if (fail && fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adler32_frame_checker.sv
// Randomized self-checking bench for adler32_frame_checker against a frame-level timing model.
module tb_adler32_frame_checker;
  localparam int SIZE_W  = 32;
  localparam int TIMEOUT = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SIZE_W-1:0] size = '0;
  logic              size_valid = 1'b0;
  logic              data_start = 1'b0;
  logic [7:0]        data = '0;
  logic [31:0]       checksum = '0;
  logic              checksum_valid = 1'b0;
  logic              pass, fail, timeout;
  logic [31:0]       rx_checksum;
`ifdef ADLER32_FAIL_COUNT_EN
  logic [15:0]       fail_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  adler32_frame_checker #(.SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .size(size), .size_valid(size_valid),
    .data_start(data_start), .data(data), .checksum(checksum),
    .checksum_valid(checksum_valid), .pass(pass), .fail(fail),
    .timeout(timeout), .rx_checksum(rx_checksum)
`ifdef ADLER32_FAIL_COUNT_EN
    , .fail_count(fail_count)
`endif
  );

  always #5 clk = ~clk;

  // Frame model: cycles are counted from the data_start edge (0). g<0 means the generator is silent.
  function automatic void model(input int sz, input int g, input logic [31:0] cs,
                                input logic [31:0] tw, output int v, output logic [2:0] pft);
    int last, tend;
    last = (sz == 0) ? 0 : sz - 1;
    tend = (sz == 0) ? 3 : sz + 3;
    if (g < 0) begin
      v   = last + TIMEOUT + 1;
      pft = 3'b011;
    end else begin
      v   = (last + g > tend) ? last + g : tend;
      pft = (cs == tw) ? 3'b100 : 3'b010;
    end
  endfunction

  // Drives one frame and reports the first verdict cycle, its {pass,fail,timeout}, rx_checksum
  // at that cycle, and how many cycles showed any verdict output.
  task automatic run_frame(input int sz, input logic [31:0] tw, input int g, input logic [31:0] cs,
                           input string pl, input bit do_size, input bit ovl,
                           input logic [SIZE_W-1:0] ovl_size,
                           output int obs_v, output logic [2:0] obs_pft,
                           output logic [31:0] obs_rx, output int nz);
    logic [7:0] q[$];
    logic [7:0] b;
    int last;
    last = (sz == 0) ? 0 : sz - 1;
    obs_v = -1; obs_pft = '0; obs_rx = '0; nz = 0;
    if (do_size) begin
      size = SIZE_W'(sz); size_valid = 1'b1;
      @(posedge clk); #1;
      size_valid = 1'b0;
    end
    for (int i = 0; i < sz; i++) begin
      b = (i < pl.len()) ? pl[i] : 8'($urandom);
      q.push_back(b);
    end
    for (int k = 3; k >= 0; k--) q.push_back(tw[8*k +: 8]);
    for (int n = 0; n < sz + TIMEOUT + 8; n++) begin
      data_start     = (n == 0);
      data           = (n < q.size()) ? q[n] : 8'($urandom);
      checksum_valid = (g >= 0) && (n == last + g);
      checksum       = checksum_valid ? cs : $urandom;
      if (ovl && n == 0) begin size = ovl_size; size_valid = 1'b1; end
      @(posedge clk); #1;
      size_valid = 1'b0;
      if (pass || fail || timeout) begin
        nz++;
        if (obs_v < 0) begin obs_v = n; obs_pft = {pass, fail, timeout}; obs_rx = rx_checksum; end
      end
    end
    data_start = 1'b0; checksum_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({pass, fail, timeout} !== 3'b000 || rx_checksum !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: pft=%b rx=%h, required pft=000 rx=00000000", {pass, fail, timeout}, rx_checksum);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    int ov, nz, ev; logic [2:0] op, ep; logic [31:0] orx;
    run_frame(9, 32'h11E60398, 2, 32'h11E60398, "Wikipedia", 1'b1, 1'b0, '0, ov, op, orx, nz);
    model(9, 2, 32'h11E60398, 32'h11E60398, ev, ep);
    n_cmp++; if (ov !== ev)  begin n_bad++; $display("FAIL good_latency: cycle %0d, required %0d", ov, ev); end
    n_cmp++; if (op !== 3'b100) begin n_bad++; $display("FAIL good_verdict: pft=%b, required 100", op); end
    n_cmp++; if (orx !== 32'h11E60398) begin n_bad++; $display("FAIL good_rx: %h, required 11e60398", orx); end
    n_cmp++; if (nz !== 1) begin n_bad++; $display("FAIL good_pulse_len: %0d cycles, required 1", nz); end
  endtask

  task automatic test_corrupt_trailer();
    int ov, nz, ev; logic [2:0] op, ep; logic [31:0] orx;
    run_frame(9, 32'h11E60399, 2, 32'h11E60398, "Wikipedia", 1'b1, 1'b0, '0, ov, op, orx, nz);
    model(9, 2, 32'h11E60398, 32'h11E60399, ev, ep);
    n_cmp++; if (ov !== ev)  begin n_bad++; $display("FAIL corrupt_latency: cycle %0d, required %0d", ov, ev); end
    n_cmp++; if (op !== ep)  begin n_bad++; $display("FAIL corrupt_verdict: pft=%b, required %b", op, ep); end
    n_cmp++; if (orx !== 32'h11E60399) begin n_bad++; $display("FAIL corrupt_rx: %h, required 11e60399", orx); end
  endtask

  task automatic test_generator_silent();
    int ov, nz, ev; logic [2:0] op, ep; logic [31:0] orx;
    run_frame(3, 32'hA5A5_0F0F, -1, '0, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
    model(3, -1, '0, 32'hA5A5_0F0F, ev, ep);
    n_cmp++; if (ov !== 13) begin n_bad++; $display("FAIL silent_latency: cycle %0d, required 13", ov); end
    n_cmp++; if (op !== ep) begin n_bad++; $display("FAIL silent_verdict: pft=%b, required %b", op, ep); end
    n_cmp++; if (nz !== 1)  begin n_bad++; $display("FAIL silent_pulse_len: %0d cycles, required 1", nz); end
  endtask

  task automatic test_late_size0();
    int ov, nz, ev; logic [2:0] op, ep; logic [31:0] orx;
    run_frame(0, 32'h00000001, 5, 32'h00000001, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
    model(0, 5, 32'h00000001, 32'h00000001, ev, ep);
    n_cmp++; if (ov !== 5 || ev !== 5) begin n_bad++; $display("FAIL late_latency: cycle %0d, required 5", ov); end
    n_cmp++; if (op !== 3'b100) begin n_bad++; $display("FAIL late_verdict: pft=%b, required 100", op); end
    n_cmp++; if (orx !== 32'h00000001) begin n_bad++; $display("FAIL late_rx: %h, required 00000001", orx); end
  endtask

  task automatic test_size_overlap();
    int ov, nz, ev; logic [2:0] op, ep; logic [31:0] orx;
    run_frame(5, 32'h1234_5678, 1, 32'h1234_5678, "", 1'b1, 1'b1, 32'd2, ov, op, orx, nz);
    model(5, 1, 32'h1234_5678, 32'h1234_5678, ev, ep);
    n_cmp++; if (ov !== ev || op !== ep) begin n_bad++; $display("FAIL overlap_old_size: cycle %0d pft=%b, required %0d %b", ov, op, ev, ep); end
    run_frame(2, 32'h8765_4321, 3, 32'h8765_4321, "", 1'b0, 1'b0, '0, ov, op, orx, nz);
    model(2, 3, 32'h8765_4321, 32'h8765_4321, ev, ep);
    n_cmp++; if (ov !== ev || op !== ep) begin n_bad++; $display("FAIL overlap_new_size: cycle %0d pft=%b, required %0d %b", ov, op, ev, ep); end
  endtask

  task automatic test_reset_mid_frame();
    int ov, nz, ev; logic [2:0] op, ep; logic [31:0] orx;
    size = 100; size_valid = 1'b1; @(posedge clk); #1; size_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      data_start = (n == 0); data = 8'($urandom);
      checksum_valid = (n == 5); checksum = 32'hDEAD_BEEF;
      @(posedge clk); #1;
    end
    data_start = 1'b0; checksum_valid = 1'b0;
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({pass, fail, timeout} !== 3'b000 || rx_checksum !== 32'h0) begin
      n_bad++; $display("FAIL reset_async: pft=%b rx=%h, required 000 00000000", {pass, fail, timeout}, rx_checksum);
    end
    nz = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (pass || fail || timeout) nz++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      data = 8'($urandom); @(posedge clk); #1;
      if (pass || fail || timeout) nz++;
    end
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL reset_no_verdict: %0d verdict cycles, required 0", nz); end
    run_frame(6, 32'h0BAD_F00D, 4, 32'h0BAD_F00D, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
    model(6, 4, 32'h0BAD_F00D, 32'h0BAD_F00D, ev, ep);
    n_cmp++; if (ov !== ev || op !== ep || orx !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL reset_next_frame: cycle %0d pft=%b rx=%h, required %0d %b 0badf00d", ov, op, orx, ev, ep);
    end
  endtask

  task automatic test_random_frames();
    int ov, nz, ev, sz, g; logic [2:0] op, ep; logic [31:0] orx, tw, cs;
    for (int f = 0; f < 30; f++) begin
      sz = $urandom_range(0, 20);
      tw = $urandom;
      cs = ($urandom_range(0, 1) == 1) ? tw : tw ^ (32'h1 << $urandom_range(0, 31));
      g  = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range((sz >= 2) ? 0 : 1, TIMEOUT);
      run_frame(sz, tw, g, cs, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
      model(sz, g, cs, tw, ev, ep);
      n_cmp++;
      if (ov !== ev || op !== ep || orx !== tw || nz !== 1) begin
        n_bad++;
        $display("FAIL random_frame %0d (size %0d g %0d): cycle %0d pft=%b rx=%h n=%0d, required %0d %b %h 1",
                 f, sz, g, ov, op, orx, nz, ev, ep, tw);
      end
    end
  endtask

  task automatic test_fail_count();
    int ov, nz, ev, fails; logic [2:0] op, ep; logic [31:0] orx;
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
    fails = 0;
    for (int f = 0; f < 4; f++) begin
      case (f)
        0: run_frame(4, 32'h1111_1111, 2, 32'h1111_1112, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
        1: run_frame(1, 32'h2222_2222, -1, '0, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
        2: run_frame(0, 32'h3333_3333, 6, 32'h0, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
        default: run_frame(7, 32'h4444_4444, 3, 32'h4444_4444, "", 1'b1, 1'b0, '0, ov, op, orx, nz);
      endcase
      if (op[1]) fails++;
    end
    n_cmp++; if (fails !== 3) begin n_bad++; $display("FAIL fc_frames: %0d failing verdicts, required 3", fails); end
`ifdef ADLER32_FAIL_COUNT_EN
    n_cmp++; if (fail_count !== 16'd3) begin n_bad++; $display("FAIL fail_count: %0d, required 3", fail_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_corrupt_trailer();
    test_generator_silent();
    test_late_size0();
    test_size_overlap();
    test_reset_mid_frame();
    test_random_frames();
    test_fail_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
